// File: rtl/noise_addr_if.sv
// Control/status bundle between the noise sequencer (master) and noise_addr_gen (slave).
interface noise_addr_if #(
  parameter int DIV_W = 16
);
  logic             noise_en;
  logic             seed_load;
  logic [31:0]      seed_a;
  logic [31:0]      seed_b;
  logic [DIV_W-1:0] rate_div;
  logic [10:0]      orbit_sin_addr;
  logic [9:0]       orbit_log_addr;
  logic             addr_valid;
  logic             noise_valid;
  logic             busy;

  modport master (
    output noise_en, seed_load, seed_a, seed_b, rate_div,
    input  orbit_sin_addr, orbit_log_addr, addr_valid, noise_valid, busy
  );

  modport slave (
    input  noise_en, seed_load, seed_a, seed_b, rate_div,
    output orbit_sin_addr, orbit_log_addr, addr_valid, noise_valid, busy
  );
endinterface

// File: rtl/noise_addr_gen.sv
// Dual Galois-LFSR address generator for the sine/log ROM-multiplier noise stage.
// Optional NOISE_LOG_ZERO_GUARD_EN: remaps a log address of 0 to 1 (LFSR sequence unchanged).
module noise_addr_gen #(
  parameter logic [31:0] SEED_A   = 32'hACE1_2468,
  parameter logic [31:0] SEED_B   = 32'h1357_BDF1,
  parameter int          DIV_W    = 16,
  parameter int          PIPE_LAT = 3
) (
  input  logic        clk100,
  input  logic        rst_n,
  noise_addr_if.slave bus
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_LOAD = 2'd1;
  localparam logic [1:0]  S_RUN  = 2'd2;
  localparam logic [31:0] POLY   = 32'h0040_0007;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [9:0] log_guard(input logic [9:0] a);
`ifdef NOISE_LOG_ZERO_GUARD_EN
    return (a == 10'd0) ? 10'd1 : a;
`else
    return a;
`endif
  endfunction

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [DIV_W-1:0]    r_cnt;
  logic                w_tick;
  logic [31:0]         r_lfsr_a;
  logic [31:0]         r_lfsr_b;
  logic [31:0]         w_lfsr_a_nxt;
  logic [31:0]         w_lfsr_b_nxt;
  logic [10:0]         r_sin_addr;
  logic [9:0]          r_log_addr;
  logic                r_addr_vld;
  logic [PIPE_LAT-1:0] r_vld_pipe;

  // seed_load overrides everything; LOAD always falls back to IDLE
  always_comb begin
    w_next_state = r_state;
    if (bus.seed_load) begin
      w_next_state = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = bus.noise_en ? S_RUN : S_IDLE;
        S_RUN:   w_next_state = bus.noise_en ? S_RUN : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // A tick needs RUN now and next cycle, so the edge that leaves RUN never steps
  assign w_tick       = (r_state == S_RUN) && (w_next_state == S_RUN) && (r_cnt >= bus.rate_div);
  assign w_lfsr_a_nxt = lfsr_step(r_lfsr_a);
  assign w_lfsr_b_nxt = lfsr_step(r_lfsr_b);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_tick || (r_state != S_RUN) || (w_next_state != S_RUN)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Stage 0: LFSR state and registered addresses
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr_a   <= SEED_A;
      r_lfsr_b   <= SEED_B;
      r_sin_addr <= '0;
      r_log_addr <= '0;
      r_addr_vld <= 1'b0;
    end else begin
      r_addr_vld <= w_tick;
      if (bus.seed_load) begin
        r_lfsr_a <= (bus.seed_a == 32'h0) ? SEED_A : bus.seed_a;
        r_lfsr_b <= (bus.seed_b == 32'h0) ? SEED_B : bus.seed_b;
      end else if (w_tick) begin
        r_lfsr_a   <= w_lfsr_a_nxt;
        r_lfsr_b   <= w_lfsr_b_nxt;
        r_sin_addr <= w_lfsr_a_nxt[31:21];
        r_log_addr <= log_guard(w_lfsr_b_nxt[31:22]);
      end
    end
  end

  // Stage 1..PIPE_LAT: valid delay line, frozen with the downstream clock-enable
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else if (bus.seed_load || (r_state == S_LOAD)) begin
      r_vld_pipe <= '0;
    end else if (bus.noise_en) begin
      r_vld_pipe[0] <= r_addr_vld;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
    end
  end

  assign bus.orbit_sin_addr = r_sin_addr;
  assign bus.orbit_log_addr = r_log_addr;
  assign bus.addr_valid     = r_addr_vld;
  assign bus.noise_valid    = r_vld_pipe[PIPE_LAT-1];
  assign bus.busy           = (r_state == S_RUN);

endmodule

// File: tb/tb_noise_addr_gen.sv
// Directed bench for noise_addr_gen: rate control, seeding, freeze, priority and async reset.
module tb_noise_addr_gen;

  localparam logic [31:0] SEED_A = 32'hACE1_2468;
  localparam logic [31:0] SEED_B = 32'h1357_BDF1;

  logic        clk100 = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [31:0] exp_zero_log;

  noise_addr_if #(.DIV_W(16)) bus ();

  noise_addr_gen #(
    .SEED_A  (SEED_A),
    .SEED_B  (SEED_B),
    .DIV_W   (16),
    .PIPE_LAT(3)
  ) dut (
    .clk100(clk100),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ 32'h0040_0007;
    return n;
  endfunction

  function automatic logic [31:0] exp_log(input logic [31:0] b);
    logic [9:0] a;
    a = b[31:22];
`ifdef NOISE_LOG_ZERO_GUARD_EN
    if (a == 10'd0) a = 10'd1;
`endif
    return 32'(a);
  endfunction

  task automatic step();
    @(posedge clk100);
    #2;
  endtask

  task automatic check_addr(input string tag);
    check({tag, "_sin"}, 32'(bus.orbit_sin_addr), 32'(m_a[31:21]));
    check({tag, "_log"}, 32'(bus.orbit_log_addr), exp_log(m_b));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.noise_en  = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_a    = 32'h0;
    bus.seed_b    = 32'h0;
    bus.rate_div  = 16'd0;
    repeat (2) step();
    check("rst_sin",  32'(bus.orbit_sin_addr), 32'h0);
    check("rst_log",  32'(bus.orbit_log_addr), 32'h0);
    check("rst_av",   32'(bus.addr_valid),     32'h0);
    check("rst_nv",   32'(bus.noise_valid),    32'h0);
    check("rst_busy", 32'(bus.busy),           32'h0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(bus.busy), 32'h0);

    // every-cycle update
    bus.noise_en = 1'b1;
    step();
    check("e0_busy", 32'(bus.busy), 32'h1);
    check("e0_av",   32'(bus.addr_valid), 32'h0);
    m_a = SEED_A;
    m_b = SEED_B;
    for (int i = 1; i <= 20; i++) begin
      step();
      m_a = ref_step(m_a);
      m_b = ref_step(m_b);
      if (i == 1) begin
        check("hand_sin", 32'(bus.orbit_sin_addr), 32'h2CC);
        check("hand_log", 32'(bus.orbit_log_addr), 32'h9A);
      end
      check("ec_av", 32'(bus.addr_valid), 32'h1);
      check_addr("ec");
      check("ec_nv", 32'(bus.noise_valid), 32'(i >= 4));
    end

    // divided rate, then rate lowered below the running count
    bus.rate_div = 16'd3;
    for (int d = 1; d <= 13; d++) begin
      logic e_av;
      logic e_nv;
      step();
      e_av = (d == 4) || (d == 8) || (d == 11) || (d == 13);
      e_nv = (d <= 3) || (d == 7) || (d == 11);
      if (e_av) begin
        m_a = ref_step(m_a);
        m_b = ref_step(m_b);
      end
      check("div_av", 32'(bus.addr_valid), 32'(e_av));
      check_addr("div");
      check("div_nv", 32'(bus.noise_valid), 32'(e_nv));
      if (d == 10) bus.rate_div = 16'd1;
    end

    // drain the valid pipe, then freeze right after an addr_valid
    bus.rate_div = 16'd7;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("drain_av", 32'(bus.addr_valid), 32'h0);
      check("drain_nv", 32'(bus.noise_valid), 32'((e == 1) || (e == 3)));
    end
    bus.rate_div = 16'd3;
    step();
    m_a = ref_step(m_a);
    m_b = ref_step(m_b);
    check("fz_tick_av", 32'(bus.addr_valid), 32'h1);
    check_addr("fz_tick");
    step();
    check("fz_pre_av", 32'(bus.addr_valid), 32'h0);
    bus.noise_en = 1'b0;
    for (int z = 1; z <= 5; z++) begin
      step();
      check("fz_av",   32'(bus.addr_valid),  32'h0);
      check("fz_busy", 32'(bus.busy),        32'h0);
      check("fz_nv",   32'(bus.noise_valid), 32'h0);
      check_addr("fz_hold");
    end
    bus.noise_en = 1'b1;
    step();
    check("re1_busy", 32'(bus.busy), 32'h1);
    check("re1_nv",   32'(bus.noise_valid), 32'h0);
    step();
    check("re2_nv", 32'(bus.noise_valid), 32'h1);
    check("re2_av", 32'(bus.addr_valid),  32'h0);
    for (int r = 3; r <= 5; r++) begin
      step();
      if (r == 5) begin
        m_a = ref_step(m_a);
        m_b = ref_step(m_b);
      end
      check("re_av", 32'(bus.addr_valid), 32'(r == 5));
      check_addr("re");
    end

    // seed_load with noise_en high: LOAD wins, zero sine seed falls back to SEED_A
    bus.seed_load = 1'b1;
    bus.seed_a    = 32'h0;
    bus.seed_b    = 32'h0000_0001;
    bus.rate_div  = 16'd0;
`ifdef NOISE_LOG_ZERO_GUARD_EN
    exp_zero_log = 32'h1;
`else
    exp_zero_log = 32'h0;
`endif
    for (int l = 1; l <= 7; l++) begin
      step();
      if (l == 1) bus.seed_load = 1'b0;
      if (l == 4) begin
        m_a = ref_step(SEED_A);
        m_b = 32'h0000_0002;
        check("zs_sin", 32'(bus.orbit_sin_addr), 32'h2CC);
        check("zs_log", 32'(bus.orbit_log_addr), exp_zero_log);
      end else if (l > 4) begin
        m_a = ref_step(m_a);
        m_b = ref_step(m_b);
        check_addr("ld_run");
      end
      check("ld_busy", 32'(bus.busy),        32'(l >= 3));
      check("ld_av",   32'(bus.addr_valid),  32'(l >= 4));
      check("ld_nv",   32'(bus.noise_valid), 32'(l == 7));
    end

    // asynchronous reset between edges
    #1 rst_n = 1'b0;
    #1;
    check("arst_sin",  32'(bus.orbit_sin_addr), 32'h0);
    check("arst_log",  32'(bus.orbit_log_addr), 32'h0);
    check("arst_av",   32'(bus.addr_valid),     32'h0);
    check("arst_nv",   32'(bus.noise_valid),    32'h0);
    check("arst_busy", 32'(bus.busy),           32'h0);
    bus.noise_en = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("rel_busy", 32'(bus.busy), 32'h0);
    bus.noise_en = 1'b1;
    step();
    check("rel_e0_busy", 32'(bus.busy), 32'h1);
    step();
    check("rel_av",  32'(bus.addr_valid),     32'h1);
    check("rel_sin", 32'(bus.orbit_sin_addr), 32'h2CC);
    check("rel_log", 32'(bus.orbit_log_addr), exp_log(ref_step(SEED_B)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
